// File: rtl/instr_mem_loadable.sv
// Byte-addressed, big-endian instruction memory with a streaming program-load port.
// Storage is zeroed after every reset; registered word-aligned fetches are served only while idle.
module instr_mem_loadable #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 256
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           fetch_en,
  input  logic                                           stall,
  input  logic [ADDR_W-1:0]                              address,
  output logic [DATA_W-1:0]                              instruction,
  output logic                                           instr_valid,
  output logic                                           fault,
  output logic                                           busy,
  input  logic                                           prog_start,
  input  logic                                           prog_valid,
  input  logic [DATA_W-1:0]                              prog_data,
  input  logic                                           prog_last,
  output logic                                           prog_ready,
  output logic [$clog2(DEPTH_BYTES/(DATA_W/8)):0]        load_count,
  output logic [1:0]                                     dbg_state
);

  localparam int BYTES       = DATA_W / 8;
  localparam int DEPTH_WORDS = DEPTH_BYTES / BYTES;
  localparam int PTR_W       = $clog2(DEPTH_WORDS);
  localparam int CNT_W       = PTR_W + 1;
  localparam int ALIGN_W     = $clog2(BYTES);
  localparam int MEM_AW      = $clog2(DEPTH_BYTES);

  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_BYTES - BYTES);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Load port handshake: a word is transferred on a rising edge where
  // prog_valid and prog_ready are both high; prog_ready is high only in LOAD
  // and depends on state alone, never combinationally on prog_valid.

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;

  logic [7:0]         mem [DEPTH_BYTES];

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic [MEM_AW-1:0]  wr_base;
  logic [MEM_AW-1:0]  rd_base;
  logic [DATA_W-1:0]  rd_word;
  logic               addr_ok;
  logic               fetch_go;

  // Next-state, pointer, count and storage write control.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + PTR_W'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (prog_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (prog_valid) begin
          wr_en   = 1'b1;
          wr_data = prog_data;
          ptr_d   = ptr_q + PTR_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          if (prog_last || (ptr_q == LAST_PTR)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign wr_base = {ptr_q, {ALIGN_W{1'b0}}};
  assign rd_base = address[MEM_AW-1:0];

  // The full address is compared, so aliases above the storage size fault.
  assign addr_ok  = (address[ALIGN_W-1:0] == '0) && (address <= LAST_ADDR);
  assign fetch_go = (state_q == ST_IDLE) && !prog_start && fetch_en && !stall;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      rd_word[DATA_W-1-8*i -: 8] = mem[rd_base + MEM_AW'(i)];
    end
  end

  // Fetch outputs: stall freezes all three; otherwise valid/fault pulse per request.
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (!stall) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
      if (fetch_go) begin
        valid_d = 1'b1;
        if (addr_ok) begin
          instr_d = rd_word;
        end else begin
          instr_d = '0;
          fault_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Storage has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[wr_base + MEM_AW'(i)] <= wr_data[DATA_W-1-8*i -: 8];
      end
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign busy        = (state_q != ST_IDLE);
  assign prog_ready  = (state_q == ST_LOAD);
  assign load_count  = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed-plus-random bench for instr_mem_loadable against a word-array reference model.
module tb_instr_mem_loadable;

  localparam int NW = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        stall;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fault;
  logic        busy;
  logic        prog_start;
  logic        prog_valid;
  logic [31:0] prog_data;
  logic        prog_last;
  logic        prog_ready;
  logic [6:0]  load_count;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // Reference model: program words, load progress and expected fetch outputs.
  logic [31:0] ref_mem [NW];
  int          m_ptr;
  int          m_cnt;
  bit          m_loading;
  logic [31:0] exp_instr;
  logic        exp_valid;
  logic        exp_fault;
  logic [31:0] load_q [$];

  instr_mem_loadable dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .address     (address),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .fault       (fault),
    .busy        (busy),
    .prog_start  (prog_start),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .prog_ready  (prog_ready),
    .load_count  (load_count),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_fetch(input logic [31:0] a, output logic [31:0] ins,
                                      output logic flt);
    if ((a % 4) != 0 || a > 32'd252) begin
      ins = 32'h0;
      flt = 1'b1;
    end else begin
      ins = ref_mem[a / 4];
      flt = 1'b0;
    end
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, "_instr"}, instruction, exp_instr);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(exp_valid));
    chk({tag, "_fault"}, 32'(fault), 32'(exp_fault));
  endtask

  task automatic fetch_chk(input logic [31:0] a);
    fetch_en = 1'b1;
    stall    = 1'b0;
    address  = a;
    tick();
    fetch_en = 1'b0;
    model_fetch(a, exp_instr, exp_fault);
    exp_valid = 1'b1;
    chk_outputs("fetch");
  endtask

  task automatic do_reset(input int n);
    int bc;
    reset = 1'b1;
    repeat (n) tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_ready", 32'(prog_ready), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    m_cnt = 0;
    m_loading = 1'b0;
    exp_instr = 32'h0;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      tick();
    end
    chk("busy_cycles", 32'(bc), 32'(NW));
  endtask

  // Streams n words from load_q; toggle inserts an idle cycle (with a fetch attempt) before each.
  task automatic load_words(input int n, input bit use_last, input bit toggle, input bit fetch_at_start);
    prog_start = 1'b1;
    fetch_en   = fetch_at_start;
    address    = 32'h0;
    tick();
    prog_start = 1'b0;
    fetch_en   = 1'b0;
    m_loading  = 1'b1;
    m_ptr      = 0;
    m_cnt      = 0;
    chk("ld_busy0", 32'(busy), 32'd1);
    chk("ld_ready0", 32'(prog_ready), 32'd1);
    chk("ld_count0", 32'(load_count), 32'd0);
    chk("ld_valid0", 32'(instr_valid), 32'd0);
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      w = load_q.pop_front();
      if (toggle) begin
        prog_valid = 1'b0;
        fetch_en   = m_loading;
        address    = 32'($urandom_range(0, NW - 1) * 4);
        tick();
        fetch_en = 1'b0;
        if (m_loading) chk("ld_nofetch", 32'(instr_valid), 32'd0);
      end
      prog_valid = 1'b1;
      prog_data  = w;
      prog_last  = use_last && (k == n - 1);
      tick();
      if (m_loading) begin
        ref_mem[m_ptr] = w;
        m_ptr++;
        m_cnt++;
        if (prog_last || m_ptr == NW) m_loading = 1'b0;
      end
      chk("ld_count", 32'(load_count), 32'(m_cnt));
      chk("ld_ready", 32'(prog_ready), 32'(m_loading));
      chk("ld_busy", 32'(busy), 32'(m_loading));
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    exp_valid  = 1'b0;
    exp_fault  = 1'b0;
  endtask

  task automatic random_fetches(input int n);
    for (int i = 0; i < n; i++) begin
      bit fe;
      bit st;
      logic [31:0] a;
      fe = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 4) == 0);
      a  = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, NW - 1) * 4) : $urandom;
      fetch_en = fe;
      stall    = st;
      address  = a;
      tick();
      if (!st) begin
        if (fe) begin
          model_fetch(a, exp_instr, exp_fault);
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
          exp_fault = 1'b0;
        end
      end
      chk_outputs("rand");
    end
    fetch_en = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; stall = 1'b0; address = 32'h0;
    prog_start = 1'b0; prog_valid = 1'b0; prog_data = 32'h0; prog_last = 1'b0;

    // Reset, clear sweep, first fetch of zeroed storage.
    do_reset(2);
    chk("idle_ready", 32'(prog_ready), 32'd0);
    fetch_chk(32'h0);

    // Three-word load terminated by prog_last.
    load_q = {32'h8001060A, 32'h04011000, 32'h0C011800};
    load_words(3, 1'b1, 1'b0, 1'b0);
    chk("t2_count", 32'(load_count), 32'd3);
    fetch_chk(32'h00);
    fetch_chk(32'h04);
    fetch_chk(32'h08);
    fetch_chk(32'h0C);

    // Boundaries and faults; a stalled fault holds.
    fetch_chk(32'h06);
    stall = 1'b1; fetch_en = 1'b1; address = 32'h0;
    tick();
    chk_outputs("stall_fault");
    stall = 1'b0; fetch_en = 1'b0;
    fetch_chk(32'h100);
    fetch_chk(32'hFC);
    fetch_chk(32'h8000_0000);
    fetch_chk(32'hFFFF_FFFC);
    fetch_chk(32'h01);

    // Stall hold then release.
    fetch_chk(32'h00);
    stall = 1'b1; fetch_en = 1'b1; address = 32'h04;
    repeat (3) begin
      tick();
      chk_outputs("stall_hold");
    end
    stall = 1'b0;
    tick();
    fetch_en = 1'b0;
    model_fetch(32'h04, exp_instr, exp_fault);
    exp_valid = 1'b1;
    chk_outputs("stall_rel");
    tick();
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    chk_outputs("idle_nofetch");
    random_fetches(30);

    // Full load with toggling valid, no prog_last; the 65th word must be ignored.
    for (int i = 0; i < NW + 1; i++) load_q.push_back($urandom);
    load_words(NW + 1, 1'b0, 1'b1, 1'b1);
    chk("t5_count", 32'(load_count), 32'(NW));
    chk("t5_state_idle", 32'(busy), 32'd0);
    fetch_chk(32'h00);
    fetch_chk(32'hFC);
    random_fetches(40);

    // Reset in the middle of a load discards it and re-zeroes storage.
    for (int i = 0; i < 4; i++) load_q.push_back($urandom);
    load_words(2, 1'b0, 1'b0, 1'b0);
    load_q.delete();
    do_reset(1);
    chk("t6_count", 32'(load_count), 32'd0);
    fetch_chk(32'h00);
    fetch_chk(32'h04);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised byte-addressed instruction memory for the CPU fetch stage, with a streaming program-load port so programs are loaded at run time rather than hard-wired.
After reset the block zeroes its storage, then serves registered, big-endian, word-aligned fetches with fault reporting and stall hold.
Sits between the PC/IF logic and the IF/ID pipeline register; a testbench or boot controller drives the load port.

Parameters:
DATA_W, 32, instruction width in bits; multiple of 8, at least 16.
ADDR_W, 32, width of the fetch byte address.
DEPTH_BYTES, 256, storage size in bytes; multiple of DATA_W/8, power of two.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
fetch_en  in  1  fetch request this cycle.
stall  in  1  hold fetch outputs; overrides fetch_en.
address  in  ADDR_W  byte address of the instruction.
instruction  out  DATA_W  fetched instruction (registered).
instr_valid  out  1  instruction/fault valid this cycle.
fault  out  1  misaligned or out-of-range fetch.
busy  out  1  clearing or loading; fetches not served.
prog_start  in  1  begin a program load (sampled in IDLE only).
prog_valid  in  1  prog_data is valid.
prog_data  in  DATA_W  program word to store.
prog_last  in  1  marks the final word of the load.
prog_ready  out  1  load port accepts a word this cycle.
load_count  out  clog2(DEPTH_WORDS)+1  number of words accepted in the current or last load.

Behaviour:
- Derived values: BYTES = DATA_W/8 and DEPTH_WORDS = DEPTH_BYTES/BYTES.
- Storage is byte-granular and big-endian: the byte at address a is the instruction MSB.
- Reset values: state=CLEAR, word pointer=0, instruction=0, instr_valid=0, fault=0, busy=1, prog_ready=0, load_count=0.
- Reset does not itself alter storage; the CLEAR state zeroes it.
- State CLEAR:
  - Writes one zero word at the pointer per cycle and increments the pointer.
  - After DEPTH_WORDS writes it moves to IDLE; busy=0 from the first IDLE cycle.
  - busy=1 for exactly DEPTH_WORDS cycles after reset deasserts.
- State IDLE:
  - busy=0 and prog_ready=0.
  - If prog_start=1: next state LOAD, pointer=0, load_count=0, busy=1. A fetch in the same cycle is dropped and instr_valid=0 next cycle.
  - prog_valid and prog_last are ignored.
- State LOAD:
  - busy=1 and prog_ready=1.
  - A transfer occurs when prog_valid=1 and prog_ready=1. It writes prog_data to byte address pointer*BYTES, then increments the pointer and load_count.
  - The state returns to IDLE after a transfer with prog_last=1.
  - It also returns to IDLE after the transfer at pointer=DEPTH_WORDS-1, whatever prog_last is; extra words are never accepted.
  - Words beyond the loaded ones keep their prior contents.
- Fetch (IDLE only, 1-cycle latency):
  - If fetch_en=1 and stall=0 at edge N, the outputs update at edge N+1 and instr_valid=1.
  - Address aligned (low clog2(BYTES) bits zero) and address <= DEPTH_BYTES-BYTES: instruction = the stored word, fault=0.
  - Otherwise: instruction=0, fault=1.
  - Address bits above the range check take part in the comparison; there is no wrap-around.
  - stall=1 in any state: instruction, instr_valid and fault all hold.
  - fetch_en=0 and stall=0: instr_valid=0 and fault=0; instruction holds its last value.
- In CLEAR and LOAD, with stall=0: instr_valid=0, fault=0, instruction holds.
- Reset mid-operation: reset in any state, including mid-LOAD, returns to CLEAR. A partial load is discarded and storage is re-zeroed.
- No read/write hazard exists because fetches are never served during LOAD or CLEAR.

Test Plan:
1. Defaults; reset high for 2 cycles, then released -> busy=1 for 64 cycles, then 0. Fetch 0x00 -> next cycle instruction=0x00000000, instr_valid=1, fault=0.
2. prog_start, then load 0x8001060A, 0x04011000, 0x0C011800 with prog_last on the third -> load_count=3, busy=0. Fetches 0x00/0x04/0x08 return those words; 0x0C returns 0.
3. Fetch 0x06 -> fault=1, instruction=0, instr_valid=1. Fetch 0x100 -> fault=1. Fetch 0xFC -> fault=0.
4. Fetch 0x00 (0x8001060A), then stall=1 for 3 cycles while address=0x04 and fetch_en=1 -> outputs hold 0x8001060A/valid=1. Release stall -> 0x04011000 one cycle later.
5. Load with prog_valid toggling every cycle and no prog_last -> prog_ready drops after the 64th transfer, load_count=64, state IDLE. A 65th prog_valid is ignored and word 0 is unchanged.
6. Reset asserted after 2 words of a load -> busy=1 for 64 cycles. Fetch 0x00 returns 0 and load_count=0.
